// File: rtl/fft_pkg.sv
// Shared types and width helpers for the SDF FFT stage chain.
// FFT_SCALE_EN: each stage scales by 1/2 and keeps the input width.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BFLY,
    FLUSH
  } state_t;

  function automatic int fft_ow(input int dw);
`ifdef FFT_SCALE_EN
    return dw;
`else
    return dw + 1;
`endif
  endfunction

  function automatic int fft_frame_len(input int log2d);
    return 2 << log2d;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Shift-register delay line for SDF stages: pushes one word per enabled
// cycle and always presents the oldest stored word.
module fft_delay_line #(
  parameter int W = 66,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         shift,
  input  logic [W-1:0] word,
  output logic [W-1:0] oldest
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift) begin
      mem[0] <= word;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign oldest = mem[DEPTH-1];

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF butterfly stage in single-path delay-feedback form.
// FFT_SCALE_EN: outputs and stored differences are halved (OW = DW).
module fft_sdf_stage
  import fft_pkg::*;
#(
  parameter int DW = 32,
  parameter int LOG2D = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_start,
  input  logic                  in_end,
  input  logic [DW-1:0]         in_real,
  input  logic [DW-1:0]         in_img,
  output logic                  out_valid,
  output logic                  out_start,
  output logic                  out_end,
  output logic [fft_ow(DW)-1:0] out_real,
  output logic [fft_ow(DW)-1:0] out_img
);

  localparam int D  = 1 << LOG2D;
  localparam int OW = fft_ow(DW);
  localparam int XW = DW + 1;
  localparam int CW = LOG2D + 1;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] FILL_LAST = CW'(D - 1);
  localparam logic [CW-1:0] BFLY_FIRST = CW'(D);
  localparam logic [CW-1:0] FRAME_LAST =
    CW'(fft_frame_len(LOG2D) - 1);
  localparam state_t AFTER_FIRST = (D == 1) ? BFLY : FILL;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            pend, pend_n;
  logic            ready_n;
  logic            ov_n, os_n, oe_n;
  logic [OW-1:0]   ore_n, oim_n;
  logic            shift;
  logic [2*XW-1:0] push, pop;
  logic            acc;

  logic signed [XW-1:0] a_re, a_im, b_re, b_im;
  logic signed [XW-1:0] sum_re, sum_im, dif_re, dif_im;

  function automatic logic signed [XW-1:0] scl(
    input logic signed [XW-1:0] v
  );
`ifdef FFT_SCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  assign acc = in_valid && in_ready;

  assign {a_re, a_im} = pop;
  assign b_re = {in_real[DW-1], in_real};
  assign b_im = {in_img[DW-1], in_img};

  assign sum_re = scl(a_re + b_re);
  assign sum_im = scl(a_im + b_im);
  assign dif_re = scl(a_re - b_re);
  assign dif_im = scl(a_im - b_im);

  fft_delay_line #(
    .W     (2 * XW),
    .DEPTH (D)
  ) u_dl (
    .clk    (clk),
    .shift  (shift),
    .word   (push),
    .oldest (pop)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    ov_n    = 1'b0;
    os_n    = 1'b0;
    oe_n    = 1'b0;
    ore_n   = out_real;
    oim_n   = out_img;
    shift   = 1'b0;
    push    = {b_re, b_im};
    unique case (state)
      IDLE: begin
        if (acc && in_start) begin
          shift   = 1'b1;
          cnt_n   = ONE;
          state_n = AFTER_FIRST;
        end
      end
      FILL, BFLY: begin
        if (acc) begin
          shift = 1'b1;
          // A start marker mid-frame restarts at index 0, dropping backlog
          if (in_start && cnt != '0) begin
            cnt_n   = ONE;
            pend_n  = 1'b0;
            state_n = AFTER_FIRST;
          end else if (state == FILL) begin
            if (pend) begin
              ov_n  = 1'b1;
              oe_n  = (cnt == FILL_LAST);
              ore_n = a_re[OW-1:0];
              oim_n = a_im[OW-1:0];
            end
            cnt_n = cnt + ONE;
            if (cnt == FILL_LAST) begin
              state_n = BFLY;
              pend_n  = 1'b0;
            end
          end else begin
            push  = {dif_re, dif_im};
            ov_n  = 1'b1;
            os_n  = (cnt == BFLY_FIRST);
            ore_n = sum_re[OW-1:0];
            oim_n = sum_im[OW-1:0];
            cnt_n = cnt + ONE;
            if (cnt == FRAME_LAST) begin
              cnt_n   = '0;
              pend_n  = 1'b1;
              state_n = in_end ? FLUSH : FILL;
            end
          end
        end
      end
      FLUSH: begin
        shift = 1'b1;
        push  = '0;
        ov_n  = 1'b1;
        oe_n  = (cnt == FILL_LAST);
        ore_n = a_re[OW-1:0];
        oim_n = a_im[OW-1:0];
        cnt_n = cnt + ONE;
        if (cnt == FILL_LAST) begin
          cnt_n   = '0;
          pend_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: ;
    endcase
    ready_n = (state_n != FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
      out_real  <= '0;
      out_img   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      in_ready  <= ready_n;
      out_valid <= ov_n;
      out_start <= os_n;
      out_end   <= oe_n;
      out_real  <= ore_n;
      out_img   <= oim_n;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Bench for fft_sdf_stage: table of frames plus hand sequences for
// back-to-back, gapped, aborted and reset-interrupted streams.
`timescale 1ns/1ps
module tb_fft_sdf_stage;
  import fft_pkg::*;

  localparam int DW = 32;
  localparam int LOG2D = 2;
  localparam int OW = fft_ow(DW);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_start, in_end;
  logic [DW-1:0] in_real, in_img;
  logic          out_valid, out_start, out_end;
  logic [OW-1:0] out_real, out_img;

  always #5 clk = ~clk;

  fft_sdf_stage #(
    .DW    (DW),
    .LOG2D (LOG2D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .in_end    (in_end),
    .in_real   (in_real),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_end   (out_end),
    .out_real  (out_real),
    .out_img   (out_img)
  );

  // One frame: 8 inputs, then 4 sums and 4 differences at full growth
  typedef struct packed {
    logic [7:0][31:0] re;
    logic [7:0][31:0] im;
    logic [3:0][63:0] sre;
    logic [3:0][63:0] sim;
    logic [3:0][63:0] dre;
    logic [3:0][63:0] dim;
  } frame_t;

  typedef struct packed {
    logic [63:0] re;
    logic [63:0] im;
    logic        st;
    logic        en;
  } exp_t;

  frame_t tab [5];
  exp_t   sbq [$];
  int     total = 0;
  int     bad = 0;

  localparam logic [31:0] MAXV = 32'h7fff_ffff;
  localparam logic [31:0] MINV = 32'h8000_0000;

  function automatic longint scl(input longint v);
`ifdef FFT_SCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input longint got,
                     input longint req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic put_in(input int k, input int i,
                        input logic [31:0] re, input logic [31:0] im);
    tab[k].re[i] = re;
    tab[k].im[i] = im;
  endtask

  task automatic put_out(input int k, input int j,
                         input longint sr, input longint si,
                         input longint dr, input longint di);
    tab[k].sre[j] = sr;
    tab[k].sim[j] = si;
    tab[k].dre[j] = dr;
    tab[k].dim[j] = di;
  endtask

  task automatic push_exp(input longint re, input longint im,
                          input logic st, input logic en);
    exp_t e;
    e.re = scl(re);
    e.im = scl(im);
    e.st = st;
    e.en = en;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_real", longint'($signed(out_real)), $signed(e.re));
        chk("out_img", longint'($signed(out_img)), $signed(e.im));
        chk("out_start", longint'(out_start), longint'(e.st));
        chk("out_end", longint'(out_end), longint'(e.en));
      end
    end
  end

  task automatic send(input logic [31:0] re, input logic [31:0] im,
                      input logic st, input logic en);
    int g = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 50) begin
      g++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_real  = re;
    in_img   = im;
    in_start = st;
    in_end   = en;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_end   = 1'b0;
  endtask

  task automatic run_frame(input int k, input logic last,
                           input logic gap);
    for (int i = 0; i < 8; i++) begin
      if (i >= 4)
        push_exp($signed(tab[k].sre[i-4]), $signed(tab[k].sim[i-4]),
                 i == 4, 1'b0);
      send(tab[k].re[i], tab[k].im[i], i == 0, last && i == 7);
      if (gap && i < 7) @(negedge clk);
    end
    for (int j = 0; j < 4; j++)
      push_exp($signed(tab[k].dre[j]), $signed(tab[k].dim[j]),
               1'b0, j == 3);
  endtask

  task automatic count_flush(input string name);
    int lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) lows++;
    end
    chk(name, lows, 4);
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (sbq.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk(name, sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      put_in(0, i, 32'(i + 1), 32'd0);
      put_in(3, i, 32'(i + 11), 32'd0);
    end
    for (int j = 0; j < 4; j++) begin
      put_out(0, j, 6 + 2 * j, 0, -4, 0);
      put_out(3, j, 26 + 2 * j, 0, -4, 0);
    end
    put_in(1, 0, 32'd10, -32'sd1);
    put_in(1, 1, -32'sd20, 32'd2);
    put_in(1, 2, 32'd30, -32'sd3);
    put_in(1, 3, -32'sd40, 32'd4);
    put_in(1, 4, 32'd5, 32'd1);
    put_in(1, 5, 32'd5, 32'd1);
    put_in(1, 6, -32'sd5, 32'd1);
    put_in(1, 7, -32'sd5, 32'd1);
    put_out(1, 0, 15, 0, 5, -2);
    put_out(1, 1, -15, 3, -25, 1);
    put_out(1, 2, 25, -2, 35, -4);
    put_out(1, 3, -45, 5, -35, 3);
    put_in(2, 0, MAXV, MINV);
    put_in(2, 1, MINV, MINV);
    put_in(2, 2, MAXV, 32'd0);
    put_in(2, 3, MINV, -32'sd1);
    put_in(2, 4, MAXV, MINV);
    put_in(2, 5, MINV, MAXV);
    put_in(2, 6, MINV, 32'd1);
    put_in(2, 7, MAXV, 32'd0);
    put_out(2, 0, 64'sd4294967294, -64'sd4294967296, 0, 0);
    put_out(2, 1, -64'sd4294967296, -1, 0, -64'sd4294967295);
    put_out(2, 2, -1, 1, 64'sd4294967295, -1);
    put_out(2, 3, -1, -1, -64'sd4294967295, -1);
    put_in(4, 0, 32'd21, 32'd0);
    put_in(4, 1, 32'd22, 32'd0);
    put_in(4, 2, 32'd23, 32'd0);
    put_in(4, 3, 32'd24, 32'd0);
    put_in(4, 4, 32'd31, 32'd0);
    put_in(4, 5, 32'd33, 32'd0);
    put_in(4, 6, 32'd35, 32'd0);
    put_in(4, 7, 32'd37, 32'd0);
    for (int j = 0; j < 4; j++)
      put_out(4, j, 52 + 3 * j, 0, -10 - j, 0);

    rst = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_end = 1'b0;
    in_real = '0;
    in_img = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_start", longint'(out_start), 0);
    chk("rst_out_end", longint'(out_end), 0);
    chk("rst_out_real", longint'(out_real), 0);
    chk("rst_out_img", longint'(out_img), 0);
    #2 rst = 1'b1;
    #1 chk("release_in_ready", longint'(in_ready), 0);

    for (int k = 0; k < 3; k++) begin
      run_frame(k, 1'b1, 1'b0);
      count_flush("table_flush_ready");
      drain("table_drain");
    end

    run_frame(0, 1'b0, 1'b0);
    run_frame(3, 1'b1, 1'b0);
    count_flush("b2b_flush_ready");
    drain("b2b_drain");

    run_frame(0, 1'b1, 1'b1);
    count_flush("gap_flush_ready");
    drain("gap_drain");

    for (int i = 0; i < 5; i++) begin
      if (i == 4) push_exp(6, 0, 1'b1, 1'b0);
      send(32'(i + 1), 32'd0, i == 0, 1'b0);
    end
    run_frame(4, 1'b1, 1'b0);
    count_flush("abort_flush_ready");
    drain("abort_drain");

    for (int i = 0; i < 6; i++) begin
      if (i >= 4) push_exp(6 + 2 * (i - 4), 0, i == 4, 1'b0);
      send(32'(i + 1), 32'd0, i == 0, 1'b0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_out_real", longint'(out_real), 0);
    chk("mid_rst_out_img", longint'(out_img), 0);
    chk("mid_rst_out_start", longint'(out_start), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_sbq", sbq.size(), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("mid_release_ready", longint'(in_ready), 0);
    send(32'd99, 32'd7, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    run_frame(0, 1'b1, 1'b0);
    count_flush("post_rst_flush_ready");
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
